// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with a registered read, a read-valid strobe
// and a one-word-per-cycle clear sweep that holds off requests while busy.
module ram_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  r_w,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    // DEPTH-1 is all ones, so the sweep ends exactly at the last word.
    localparam logic [ADDR_WIDTH-1:0] PtrLast = '1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        we         = 1'b0;
        waddr      = address;
        wdata      = data_in;

        unique case (state_q)
            StIdle: begin
                // A clear on the same edge as a request wins; the request is dropped.
                if (clear) begin
                    state_d = StClear;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end else if (en) begin
                    if (r_w) begin
                        we = 1'b1;
                    end else begin
                        data_out_d = mem_q[address];
                        valid_d    = 1'b1;
                    end
                end
            end
            StClear: begin
                we    = 1'b1;
                waddr = ptr_q;
                wdata = '0;
                if (ptr_q == PtrLast) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            mem_q      <= mem_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_param.sv
// Directed, table-driven bench for ram_param (DATA_WIDTH=8, ADDR_WIDTH=2); each row gives
// the inputs sampled at one posedge and the outputs expected just after it.
module tb_ram_param;

    logic       clk = 1'b0;
    logic       rst, en, r_w, clear;
    logic [1:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid, busy;

    int n_cmp = 0;
    int n_bad = 0;

    ram_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .r_w     (r_w),
        .address (address),
        .data_in (data_in),
        .clear   (clear),
        .data_out(data_out),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rw;
        logic       clr;
        logic [1:0] addr;
        logic [7:0] din;
        logic [7:0] e_do;
        logic       e_v;
        logic       e_b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic w, input logic c,
                                input logic [1:0] a, input logic [7:0] d,
                                input logic [7:0] edo, input logic ev, input logic eb);
        vec_t v;
        v.rst = r; v.en = e; v.rw = w; v.clr = c; v.addr = a; v.din = d;
        v.e_do = edo; v.e_v = ev; v.e_b = eb;
        return v;
    endfunction

    task automatic step(input logic r, input logic e, input logic w, input logic c,
                        input logic [1:0] a, input logic [7:0] d);
        rst = r; en = e; r_w = w; clear = c; address = a; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h, required %h", name, idx, got, want);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input logic [7:0] edo,
                           input logic ev, input logic eb);
        chk({name, ".data_out"}, idx, data_out, edo);
        chk({name, ".valid"}, idx, {7'd0, valid}, {7'd0, ev});
        chk({name, ".busy"}, idx, {7'd0, busy}, {7'd0, eb});
    endtask

    initial begin
        int bcnt;

        rst = 1'b0; en = 1'b0; r_w = 1'b0; clear = 1'b0; address = '0; data_in = '0;

        //            rst en rw clr addr din    do     v  b
        tbl.push_back(mk(1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0)); // reset
        tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0)); // reads after reset
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd3, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'd0, 8'hAA, 8'h00, 0, 0)); // fill
        tbl.push_back(mk(0, 1, 1, 0, 2'd1, 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h55, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'd3, 8'h0F, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd3, 8'h00, 8'h0F, 1, 0)); // read back reversed
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 8'h00, 8'h55, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'h00, 8'hAA, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2'd1, 8'h77, 8'hAA, 0, 0)); // gated write
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2'd0, 8'h00, 8'hFF, 0, 1)); // clear sweep
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h99, 8'hFF, 0, 1)); // writes while busy
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h99, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h99, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h99, 8'hFF, 0, 0)); // last sweep edge
        tbl.push_back(mk(0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd3, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'd2, 8'h5A, 8'h00, 0, 0)); // clear beats read
        tbl.push_back(mk(0, 1, 0, 1, 2'd2, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 2'd2, 8'h00, 8'h00, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].rw, tbl[i].clr, tbl[i].addr, tbl[i].din);
            chk_out("vec", i, tbl[i].e_do, tbl[i].e_v, tbl[i].e_b);
        end

        // Busy length measured with a bounded wait.
        step(0, 0, 0, 1, 2'd0, 8'h00);
        bcnt = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            bcnt++;
            step(0, 0, 0, 0, 2'd0, 8'h00);
        end
        chk("busy_cycles", 0, 8'(bcnt), 8'd4);

        // Reset in the middle of a sweep: fill, start clear, rst on 2nd busy cycle.
        for (int a = 0; a < 4; a++) begin
            step(0, 1, 1, 0, 2'(a), 8'(8'h31 + a));
        end
        step(0, 1, 0, 0, 2'd3, 8'h00);
        chk_out("pre_clr_read", 0, 8'h34, 1'b1, 1'b0);
        step(0, 0, 0, 1, 2'd0, 8'h00);
        chk_out("mid_clr_b1", 0, 8'h34, 1'b0, 1'b1);
        step(0, 0, 0, 0, 2'd0, 8'h00);
        chk_out("mid_clr_b2", 0, 8'h34, 1'b0, 1'b1);
        step(1, 1, 0, 0, 2'd0, 8'h00);
        chk_out("mid_clr_rst", 0, 8'h00, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) begin
            step(0, 1, 0, 0, 2'(a), 8'h00);
            chk_out("post_rst_read", a, 8'h00, 1'b1, 1'b0);
        end
        step(0, 0, 0, 0, 2'd0, 8'h00);
        chk_out("post_rst_idle", 0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_param.md
# ram_param

Parametrised single-port synchronous RAM, DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits. It generalises the fixed 1x4, 1x8 and 2x8 RAM cells to arbitrary width and depth. It adds a request enable, a registered read with a read-valid strobe, and a multi-cycle clear sweep with a busy flag. It serves as the standard storage element for the register-file and lab-memory exercises.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 2, address bits; DEPTH = 2**ADDR_WIDTH
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  request enable; sampled each posedge
- r_w  in  1  operation select: 1 = write, 0 = read (valid only with en=1)
- address  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- clear  in  1  start clear sweep (level sampled at posedge)
- data_out  out  DATA_WIDTH  registered read data
- valid  out  1  one-cycle strobe: data_out updated by a read
- busy  out  1  clear sweep in progress; requests dropped

## Operation
- Reset is synchronous: rst=1 at a posedge does the following, regardless of state.
  - All DEPTH words become 0.
  - data_out becomes 0, valid becomes 0, busy becomes 0.
  - The FSM goes to IDLE and the sweep pointer goes to 0.
  - rst takes priority over every other input.
- FSM states:
  - IDLE: services requests.
  - CLEAR: writes 0 to one word per cycle, walking the pointer from 0 to DEPTH-1.
- IDLE, clear=1: go to CLEAR, set pointer to 0, set busy=1. A request on the same edge is dropped, so clear beats en.
- IDLE, clear=0, en=1, r_w=1: mem[address] <= data_in. data_out unchanged; valid=0.
- IDLE, clear=0, en=1, r_w=0: data_out <= mem[address]; valid=1 for exactly the next cycle.
- IDLE, en=0: no memory change. valid=0 and data_out holds its last value.
- CLEAR, each edge: mem[pointer] <= 0.
  - If pointer == DEPTH-1: go to IDLE, busy=0.
  - Otherwise pointer increments.
  - en, r_w and clear are ignored (no restart, no queueing). valid stays 0 and data_out holds.
- Pointer is ADDR_WIDTH bits wide. The terminal compare is at DEPTH-1, so the pointer never wraps past the end of the array.
- Address covers the full range. No out-of-range case exists.
- A single port means one operation per cycle, so no read/write collision is possible. A read of an address written on an earlier edge returns the new data.
- Unwritten words read 0 after reset.

## Timing
- Write: data is stored at the posedge where en=1, r_w=1 is sampled. It is readable by a request on the next edge.
- Read latency is 1 cycle. If the request is sampled at edge k:
  - data_out and valid=1 are present from edge k to edge k+1.
  - valid drops at edge k+1 unless another read is sampled there.
- Back-to-back reads give valid=1 continuously, with data_out updating every cycle.
- Clear sampled at edge k:
  - busy=1 from edge k to edge k+DEPTH.
  - Words 0..DEPTH-1 are zeroed at edges k+1..k+DEPTH.
  - busy=0 after edge k+DEPTH.
  - The first request that can be accepted is at edge k+DEPTH+1.
- rst during CLEAR: the whole array is zero and busy=0 after that edge, and the sweep is abandoned.
- Output reset values: data_out=0, valid=0, busy=0.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2.
- Reset then read: rst 1 cycle, then read addr 0..3 back-to-back -> data_out=8'h00 each, valid high 4 consecutive cycles starting 1 cycle after first request.
- Write/read all addresses: write AA, FF, 55, 0F to addr 0..3, then read 3,2,1,0 -> data_out 0F,55,FF,AA with 1-cycle latency; valid=0 during writes.
- en gating: r_w=1, en=0, data_in=8'h77 at addr 1, then read addr 1 -> 8'hFF retained; valid=0 on cycles with en=0 and data_out holds.
- Clear sweep: after the fill above, pulse clear and assert a write of 8'h99 to addr 2 during busy. Required response:
  - busy high exactly 4 cycles.
  - The write is dropped.
  - Subsequent reads of 0..3 all return 8'h00.
- Clear vs request same edge: clear=1 with en=1, r_w=0 -> no valid strobe; busy rises next cycle.
- Reset mid-clear: fill memory, start clear, assert rst on the 2nd busy cycle -> busy=0 next cycle and all words read 8'h00.
